// File: rtl/servile_wb_decoder.sv
// servile_wb_decoder
//   N-slave Wishbone address decoder/router. A CPU request is decoded against
//   per-slave base/mask pairs, the winning slave index is latched for the whole
//   cycle, and that slave's strobe/ack/read data are routed to the CPU.
//   Unmapped addresses complete through an ERR state with UNMAPPED_RDT and a
//   one-cycle o_err pulse.
//   Optional watchdog: define SERVILE_WB_DECODER_TIMEOUT_EN to terminate an
//   ACTIVE cycle after 2**TIMEOUT_W-1 cycles without a slave ack.
// Ports
//   i_clk, i_rst_n              clock / async active-low reset
//   i_wb_cpu_*                  CPU request (adr, dat, sel, we, stb)
//   o_wb_cpu_rdt, o_wb_cpu_ack  CPU response
//   o_wb_s_*                    slave-side request, packed NS slices
//   i_wb_s_rdt, i_wb_s_ack      slave responses, packed NS slices
//   o_err                       one-cycle pulse on unmapped access / timeout
module servile_wb_decoder #(
  parameter int              NS           = 2,
  parameter logic [NS*32-1:0] S_BASE      = {NS{32'h0}},
  parameter logic [NS*32-1:0] S_MASK      = {NS{32'h0}},
  parameter logic [31:0]     UNMAPPED_RDT = 32'hDEADBEEF,
  parameter int              TIMEOUT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_wb_cpu_adr,
  input  logic [31:0]      i_wb_cpu_dat,
  input  logic [3:0]       i_wb_cpu_sel,
  input  logic             i_wb_cpu_we,
  input  logic             i_wb_cpu_stb,
  output logic [31:0]      o_wb_cpu_rdt,
  output logic             o_wb_cpu_ack,
  output logic [NS*32-1:0] o_wb_s_adr,
  output logic [NS*32-1:0] o_wb_s_dat,
  output logic [NS*4-1:0]  o_wb_s_sel,
  output logic [NS-1:0]    o_wb_s_we,
  output logic [NS-1:0]    o_wb_s_stb,
  input  logic [NS*32-1:0] i_wb_s_rdt,
  input  logic [NS-1:0]    i_wb_s_ack,
  output logic             o_err
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_e;

  state_e        state_q;
  logic [SW-1:0] sel_q;
  logic          hit_any;
  logic [SW-1:0] hit_idx;
  logic          act, tmo, s_ack, s_done, tmo_fire, err_ev;
  logic [31:0]   s_rdt;

  // Request fields are broadcast unchanged; only stb is routed.
  assign o_wb_s_adr = {NS{i_wb_cpu_adr}};
  assign o_wb_s_dat = {NS{i_wb_cpu_dat}};
  assign o_wb_s_sel = {NS{i_wb_cpu_sel}};
  assign o_wb_s_we  = {NS{i_wb_cpu_we}};

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((i_wb_cpu_adr & S_MASK[k*32 +: 32]) == S_BASE[k*32 +: 32]) begin
        hit_any = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

`ifdef SERVILE_WB_DECODER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q;
  assign tmo = (wdog_q == '1);
`else
  logic unused_tw;
  assign unused_tw = ^TIMEOUT_W;
  assign tmo       = 1'b0;
`endif

  assign act      = (state_q == ACTIVE);
  assign s_ack    = i_wb_s_ack[sel_q];
  assign s_rdt    = i_wb_s_rdt[32*sel_q +: 32];
  assign s_done   = act & i_wb_cpu_stb & s_ack;
  // A slave ack in the expiry cycle wins over the timeout.
  assign tmo_fire = act & i_wb_cpu_stb & tmo & ~s_ack;
  assign err_ev   = (state_q == ERR) | tmo_fire;

  // Stb is gated on the watchdog alone (not on ack) so a slave whose ack is
  // combinational on its stb cannot form a loop through this block.
  for (genvar k = 0; k < NS; k++) begin : g_stb
    assign o_wb_s_stb[k] = act & i_wb_cpu_stb & ~tmo & (sel_q == SW'(k));
  end

  assign o_wb_cpu_ack = s_done | err_ev;
  assign o_err        = err_ev;
  assign o_wb_cpu_rdt = err_ev ? UNMAPPED_RDT : (act ? s_rdt : 32'h0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
`ifdef SERVILE_WB_DECODER_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_wb_cpu_stb) begin
            if (hit_any) begin
              state_q <= ACTIVE;
              sel_q   <= hit_idx;
`ifdef SERVILE_WB_DECODER_TIMEOUT_EN
              wdog_q  <= '0;
`endif
            end else begin
              state_q <= ERR;
            end
          end
        end
        ACTIVE: begin
          // Abort, normal completion and timeout all return to IDLE.
          if (!i_wb_cpu_stb || s_ack || tmo) begin
            state_q <= IDLE;
          end
`ifdef SERVILE_WB_DECODER_TIMEOUT_EN
          else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servile_wb_decoder.sv
module tb_servile_wb_decoder;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [31:0]   adr = '0, dat = '0;
  logic [3:0]    sel = '0;
  logic          we = 1'b0, stb = 1'b0;
  logic [31:0]   rdt;
  logic          ack, err;
  logic [NS*32-1:0] s_adr, s_dat;
  logic [NS*4-1:0]  s_sel;
  logic [NS-1:0]    s_we, s_stb;
  logic [NS*32-1:0] s_rdt = {32'h2222_2222, 32'h1234_5678, 32'h0000_1111};
  logic [NS-1:0]    s_ack = '0;

  int checks = 0;
  int errors = 0;

  servile_wb_decoder #(
    .NS          (NS),
    .S_BASE      ({32'h8000_0000, 32'h4000_0000, 32'h0000_0000}),
    .S_MASK      ({3{32'hC000_0000}}),
    .UNMAPPED_RDT(32'hDEADBEEF),
    .TIMEOUT_W   (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wb_cpu_adr(adr),
    .i_wb_cpu_dat(dat),
    .i_wb_cpu_sel(sel),
    .i_wb_cpu_we (we),
    .i_wb_cpu_stb(stb),
    .o_wb_cpu_rdt(rdt),
    .o_wb_cpu_ack(ack),
    .o_wb_s_adr  (s_adr),
    .o_wb_s_dat  (s_dat),
    .o_wb_s_sel  (s_sel),
    .o_wb_s_we   (s_we),
    .o_wb_s_stb  (s_stb),
    .i_wb_s_rdt  (s_rdt),
    .i_wb_s_ack  (s_ack),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({s_stb, ack, err, rdt} !== {3'b000, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset: stb=%b ack=%b err=%b rdt=%h, want 000/0/0/0", s_stb, ack, err, rdt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_read();
    cyc(); adr = 32'h4000_0010; we = 1'b0; stb = 1'b1;
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b000 || ack !== 1'b0) begin
      errors++; $display("FAIL read_c0: stb=%b ack=%b, want 000/0", s_stb, ack);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b010 || ack !== 1'b0) begin
      errors++; $display("FAIL read_c1: stb=%b ack=%b, want 010/0", s_stb, ack);
    end
    cyc(); s_ack = 3'b001;  // ack from a slave that was not selected
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || s_stb !== 3'b010) begin
      errors++; $display("FAIL read_foreign_ack: ack=%b stb=%b, want 0/010", ack, s_stb);
    end
    cyc(); s_ack = 3'b010;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || rdt !== 32'h1234_5678 || err !== 1'b0) begin
      errors++; $display("FAIL read_ack: ack=%b rdt=%h err=%b, want 1/12345678/0", ack, rdt, err);
    end
    cyc(); stb = 1'b0; s_ack = '0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || rdt !== 32'h0 || s_stb !== 3'b000) begin
      errors++; $display("FAIL read_idle: ack=%b rdt=%h stb=%b, want 0/0/000", ack, rdt, s_stb);
    end
  endtask

  task automatic test_write();
    cyc(); adr = 32'h0000_0004; dat = 32'hA5A5_A5A5; sel = 4'b0011; we = 1'b1; stb = 1'b1;
    @(negedge clk);
    checks++;
    if (s_adr !== {3{32'h0000_0004}} || s_dat !== {3{32'hA5A5_A5A5}} ||
        s_sel !== 12'b0011_0011_0011 || s_we !== 3'b111) begin
      errors++;
      $display("FAIL write_bcast: adr=%h dat=%h sel=%b we=%b", s_adr, s_dat, s_sel, s_we);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b001) begin
      errors++; $display("FAIL write_stb: stb=%b, want 001", s_stb);
    end
    cyc(); s_ack = 3'b001;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || s_stb !== 3'b001 || rdt !== 32'h0000_1111) begin
      errors++; $display("FAIL write_ack: ack=%b stb=%b rdt=%h, want 1/001/00001111", ack, s_stb, rdt);
    end
    cyc(); stb = 1'b0; we = 1'b0; s_ack = '0;
  endtask

  task automatic test_unmapped();
    cyc(); adr = 32'hC000_0000; stb = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || s_stb !== 3'b000) begin
      errors++; $display("FAIL unmap_c0: ack=%b err=%b stb=%b, want 0/0/000", ack, err, s_stb);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || err !== 1'b1 || rdt !== 32'hDEADBEEF || s_stb !== 3'b000) begin
      errors++;
      $display("FAIL unmap_err: ack=%b err=%b rdt=%h stb=%b, want 1/1/deadbeef/000", ack, err, rdt, s_stb);
    end
    cyc(); stb = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || err !== 1'b0 || rdt !== 32'h0) begin
      errors++; $display("FAIL unmap_pulse: ack=%b err=%b rdt=%h, want 0/0/0", ack, err, rdt);
    end
  endtask

  task automatic test_abort();
    cyc(); adr = 32'h8000_0000; stb = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b100) begin
      errors++; $display("FAIL abort_stb: stb=%b, want 100", s_stb);
    end
    cyc(); stb = 1'b0;
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b000 || ack !== 1'b0) begin
      errors++; $display("FAIL abort_drop: stb=%b ack=%b, want 000/0", s_stb, ack);
    end
    cyc(); cyc(); cyc(); s_ack = 3'b100;
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || rdt !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_late_ack: ack=%b rdt=%h err=%b, want 0/0/0", ack, rdt, err);
    end
    cyc(); s_ack = '0;
  endtask

  // Address moves to slave 1's range mid-cycle; routing must stay on slave 0.
  task automatic test_frozen_sel();
    cyc(); adr = 32'h0000_0100; stb = 1'b1;
    cyc(); adr = 32'h4000_0100;
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b001) begin
      errors++; $display("FAIL frozen_sel: stb=%b, want 001", s_stb);
    end
    cyc(); s_ack = 3'b011;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || rdt !== 32'h0000_1111) begin
      errors++; $display("FAIL frozen_ack: ack=%b rdt=%h, want 1/00001111", ack, rdt);
    end
    cyc(); stb = 1'b0; s_ack = '0;
  endtask

  task automatic test_watchdog();
    int early_acks;
    early_acks = 0;
    cyc(); adr = 32'h4000_0000; stb = 1'b1;
`ifdef SERVILE_WB_DECODER_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      cyc();
      @(negedge clk);
      if (ack !== 1'b0 || s_stb !== 3'b010) early_acks++;
    end
    checks++;
    if (early_acks !== 0) begin
      errors++; $display("FAIL wdog_wait: early/bad cycles=%0d, want 0", early_acks);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || err !== 1'b1 || rdt !== 32'hDEADBEEF || s_stb !== 3'b000) begin
      errors++;
      $display("FAIL wdog_fire: ack=%b err=%b rdt=%h stb=%b, want 1/1/deadbeef/000", ack, err, rdt, s_stb);
    end
    cyc(); stb = 1'b0;
`else
    for (int i = 1; i <= 20; i++) begin
      cyc();
      @(negedge clk);
      if (ack !== 1'b0 || err !== 1'b0 || s_stb !== 3'b010) early_acks++;
    end
    checks++;
    if (early_acks !== 0) begin
      errors++; $display("FAIL no_wdog_wait: bad cycles=%0d, want 0", early_acks);
    end
    cyc(); stb = 1'b0;
`endif
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b000 || ack !== 1'b0) begin
      errors++; $display("FAIL wdog_end: stb=%b ack=%b, want 000/0", s_stb, ack);
    end
  endtask

  task automatic test_reset_mid();
    cyc(); adr = 32'h4000_0040; stb = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b010) begin
      errors++; $display("FAIL rstmid_pre: stb=%b, want 010", s_stb);
    end
    #1 rst_n = 1'b0; s_ack = 3'b010;
    #1;
    checks++;
    if (s_stb !== 3'b000 || ack !== 1'b0 || rdt !== 32'h0) begin
      errors++; $display("FAIL rstmid_async: stb=%b ack=%b rdt=%h, want 000/0/0", s_stb, ack, rdt);
    end
    stb = 1'b0; s_ack = '0;
    #1 rst_n = 1'b1;
    cyc(); adr = 32'h0000_0020; stb = 1'b1;
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b000) begin
      errors++; $display("FAIL rstmid_c0: stb=%b, want 000", s_stb);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (s_stb !== 3'b001) begin
      errors++; $display("FAIL rstmid_redecode: stb=%b, want 001", s_stb);
    end
    cyc(); s_ack = 3'b001;
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || rdt !== 32'h0000_1111) begin
      errors++; $display("FAIL rstmid_ack: ack=%b rdt=%h, want 1/00001111", ack, rdt);
    end
    cyc(); stb = 1'b0; s_ack = '0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_abort();
    test_frozen_sel();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
